bp_resolve_queue: RTL and testbench
===================================

# bp_resolve_queue

In-order prediction tracking queue between IF and EX. Records each fetched instruction's predictor output (taken flag and target) at fetch time. When EX resolves the instruction, the queue compares the prediction with the actual outcome. It then issues a registered update to the `bp` write port and a registered redirect/flush to IF on misprediction.

## Interface
- `s_depth`, default 3: log2 of queue depth; 8 entries by default.
- `clk`  in  1  system clock; the only clock.
- `rst`  in  1  reset; synchronous, active-high.
- `f_valid`  in  1  IF pushes one fetched instruction.
- `f_ready`  out  1  queue not full; a push is accepted only when `f_valid & f_ready`.
- `f_pc`  in  32  `rv32i_word`, PC of the fetched instruction.
- `f_taken_pred`  in  1  `r_taken_pred` sampled from `bp`.
- `f_addr_pred`  in  32  `r_addr_pred` sampled from `bp`.
- `ex_valid`  in  1  EX resolves the oldest instruction (pop).
- `ex_is_br`  in  1  resolved instruction is a BR or JAL.
- `ex_pc`  in  32  PC of the resolved instruction.
- `ex_taken`  in  1  actual `br_en`.
- `ex_target`  in  32  actual computed destination (`alu_out`).
- `flush`  in  1  external pipeline flush (exception/trap).
- `w_br_op`, `w_pc`, `w_dest`, `w_taken`  out  1/32/32/1  registered update to `bp`.
- `redirect`  out  1  one-cycle pulse: IF must restart at `redirect_pc`.
- `redirect_pc`  out  32  correct next PC.
- `count`  out  s_depth+1  current occupancy.
- `err`  out  1  sticky protocol error.
- `stat_br`, `stat_miss`  out  32  statistics counters; see Configuration.

## Operation
- Storage: circular buffer of 2^s_depth entries `{pc, taken_pred, addr_pred}`, with head/tail pointers of s_depth bits plus the count.
- Push: `f_valid & f_ready` writes the entry at the tail; the tail increments modulo depth.
- Pop: when `ex_valid` and count > 0, the head entry is compared against EX:
  - pred_next = taken_pred ? addr_pred : pc+4.
  - act_next = (ex_is_br & ex_taken) ? ex_target : pc+4.
  - mispredict = pred_next != act_next. Non-branches predicted taken are mispredicts with act_next = pc+4.
- Update: `w_br_op` = `ex_valid & ex_is_br` (registered). `w_pc`/`w_dest`/`w_taken` carry the head pc, ex_target and ex_taken. Non-branches never update `bp`.
- Mispredict handling:
  - `redirect` = 1 and `redirect_pc` = act_next.
  - The whole queue is cleared on the same edge (count = 0, head = tail = 0).
  - A push in the same cycle is discarded as wrong-path.
- `flush` behaviour:
  - Clears the queue and discards any same-cycle push.
  - A same-cycle resolve still issues its `bp` update.
  - A same-cycle resolve's redirect is suppressed.
- `err` is set (until reset) when either:
  - `ex_valid` arrives with count = 0; no pop, no update, no redirect occur.
  - `ex_pc` != head pc; the entry still pops and is processed normally.
- Simultaneous push and pop without mispredict: count is unchanged and both pointers advance.
- Full: `f_ready` = 0, even if a pop happens that cycle.
- Empty: push and pop cannot combine in one cycle. A new entry is resolvable at the earliest one cycle after its push.

## Timing
- `f_ready` and `count` are derived combinationally from the registered count only, never from current inputs.
- `w_*`, `redirect` and `redirect_pc` are registered: valid exactly one cycle after the resolve edge. `w_br_op` and `redirect` are single-cycle pulses.
- The queue is empty starting the cycle after a mispredict or flush edge.
- Reset values:
  - All outputs are 0, except `f_ready` = 1.
  - count = 0, pointers = 0, `err` = 0, statistics = 0.
  - Entry contents are don't-care.
- Reset mid-operation discards all entries and suppresses any pending update/redirect on that edge.

## Configuration
- Macro: `BP_RESOLVE_STATS_EN`.
- Defined: `stat_br` increments on every update with `w_br_op`; `stat_miss` increments on every mispredict pop, including one whose redirect was suppressed by flush. Both saturate at 0xFFFFFFFF and reset to 0.
- Undefined: both ports are tied to 0 and no counter logic is built.

## Test plan
- Push pc 0x100 (nt, 0) and pc 0x104 (t, 0x200), then resolve both as predicted (0x104 not-taken branch? no: taken to 0x200) -> no redirect; `w_br_op` pulses twice with `w_pc` 0x100 then 0x104; count returns to 0.
- Push pc 0x100 predicted nt, then resolve branch taken to 0x180 -> `redirect` = 1 and `redirect_pc` = 0x180 one cycle later; `w_taken` = 1; count = 0; a concurrent push is dropped.
- Push 8 entries -> `f_ready` = 0 and a 9th push is ignored; pop one -> `f_ready` = 1 the next cycle; push order is preserved across pointer wrap.
- Non-branch at 0x300 predicted taken to 0x400 -> `redirect_pc` = 0x304 and `w_br_op` = 0.
- `ex_valid` while empty -> `err` = 1 and stays set, with no update; `flush` together with a mispredicting resolve -> update issued, no redirect, queue empty.
- With `BP_RESOLVE_STATS_EN`: 3 branches including 1 mispredict -> `stat_br` = 3 and `stat_miss` = 1; without the macro both read 0.

Source files
------------

// File: rtl/bp_resolve_queue.sv
// In-order branch prediction tracking queue between IF and EX: records predictions at fetch,
// checks them at resolve, drives bp updates and IF redirects. Optional counters: BP_RESOLVE_STATS_EN.
module bp_resolve_queue #(
  parameter int s_depth = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               f_valid,
  output logic               f_ready,
  input  logic [31:0]        f_pc,
  input  logic               f_taken_pred,
  input  logic [31:0]        f_addr_pred,
  input  logic               ex_valid,
  input  logic               ex_is_br,
  input  logic [31:0]        ex_pc,
  input  logic               ex_taken,
  input  logic [31:0]        ex_target,
  input  logic               flush,
  output logic               w_br_op,
  output logic [31:0]        w_pc,
  output logic [31:0]        w_dest,
  output logic               w_taken,
  output logic               redirect,
  output logic [31:0]        redirect_pc,
  output logic [s_depth:0]   count,
  output logic               err,
  output logic [31:0]        stat_br,
  output logic [31:0]        stat_miss
);

  localparam int depth = 1 << s_depth;
  localparam logic [s_depth:0]   full_count = (s_depth + 1)'(depth);
  localparam logic [s_depth:0]   count_one  = (s_depth + 1)'(1);
  localparam logic [s_depth-1:0] ptr_one    = s_depth'(1);

  logic [31:0] pc_mem [depth];
  logic        tp_mem [depth];
  logic [31:0] ap_mem [depth];

  logic [s_depth-1:0] head_reg, tail_reg;
  logic [s_depth:0]   count_reg, count_next;
  logic               err_reg;
  logic               w_br_op_reg, w_taken_reg, redirect_reg;
  logic [31:0]        w_pc_reg, w_dest_reg, redirect_pc_reg;

  logic        push_ok, pop, mispredict, clear;
  logic [31:0] head_pc, head_ap, head_pc4, pred_next, act_next;
  logic        head_tp;

  assign f_ready = (count_reg != full_count);
  assign count   = count_reg;
  assign push_ok = f_valid & f_ready;
  assign pop     = ex_valid & (count_reg != '0);

  assign head_pc    = pc_mem[head_reg];
  assign head_tp    = tp_mem[head_reg];
  assign head_ap    = ap_mem[head_reg];
  assign head_pc4   = head_pc + 32'd4;
  assign pred_next  = head_tp ? head_ap : head_pc4;
  assign act_next   = (ex_is_br & ex_taken) ? ex_target : head_pc4;
  assign mispredict = pop & (pred_next != act_next);
  // A mispredict or external flush throws away everything younger, including a same-cycle push.
  assign clear      = mispredict | flush;

  always_comb begin
    count_next = count_reg;
    if (push_ok & ~pop)
      count_next = count_reg + count_one;
    else if (pop & ~push_ok)
      count_next = count_reg - count_one;
  end

  // Entry storage carries no reset; contents are only meaningful between tail and head.
  always_ff @(posedge clk) begin
    if (push_ok & ~clear) begin
      pc_mem[tail_reg] <= f_pc;
      tp_mem[tail_reg] <= f_taken_pred;
      ap_mem[tail_reg] <= f_addr_pred;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_reg        <= '0;
      tail_reg        <= '0;
      count_reg       <= '0;
      err_reg         <= 1'b0;
      w_br_op_reg     <= 1'b0;
      w_pc_reg        <= '0;
      w_dest_reg      <= '0;
      w_taken_reg     <= 1'b0;
      redirect_reg    <= 1'b0;
      redirect_pc_reg <= '0;
    end else begin
      if (clear) begin
        head_reg  <= '0;
        tail_reg  <= '0;
        count_reg <= '0;
      end else begin
        if (push_ok) tail_reg <= tail_reg + ptr_one;
        if (pop)     head_reg <= head_reg + ptr_one;
        count_reg <= count_next;
      end

      if ((ex_valid & (count_reg == '0)) | (pop & (ex_pc != head_pc)))
        err_reg <= 1'b1;

      w_br_op_reg <= pop & ex_is_br;
      if (pop) begin
        w_pc_reg    <= head_pc;
        w_dest_reg  <= ex_target;
        w_taken_reg <= ex_taken;
      end

      redirect_reg <= mispredict & ~flush;
      if (mispredict & ~flush)
        redirect_pc_reg <= act_next;
    end
  end

  assign w_br_op     = w_br_op_reg;
  assign w_pc        = w_pc_reg;
  assign w_dest      = w_dest_reg;
  assign w_taken     = w_taken_reg;
  assign redirect    = redirect_reg;
  assign redirect_pc = redirect_pc_reg;
  assign err         = err_reg;

`ifdef BP_RESOLVE_STATS_EN
  logic [31:0] stat_br_reg, stat_miss_reg;

  // Both counters saturate rather than wrap; miss counts even when flush hid the redirect.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_br_reg   <= '0;
      stat_miss_reg <= '0;
    end else begin
      if (pop & ex_is_br & (stat_br_reg != '1))
        stat_br_reg <= stat_br_reg + 32'd1;
      if (mispredict & (stat_miss_reg != '1))
        stat_miss_reg <= stat_miss_reg + 32'd1;
    end
  end

  assign stat_br   = stat_br_reg;
  assign stat_miss = stat_miss_reg;
`else
  assign stat_br   = '0;
  assign stat_miss = '0;
`endif

endmodule

// File: tb/tb_bp_resolve_queue.sv
// Directed bench for bp_resolve_queue: an entry model plus a scoreboard of expected resolve results.
module tb_bp_resolve_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        f_valid, f_ready, f_taken_pred;
  logic [31:0] f_pc, f_addr_pred;
  logic        ex_valid, ex_is_br, ex_taken, flush;
  logic [31:0] ex_pc, ex_target;
  logic        w_br_op, w_taken, redirect, err;
  logic [31:0] w_pc, w_dest, redirect_pc, stat_br, stat_miss;
  logic [3:0]  count;

  bp_resolve_queue #(.s_depth(3)) dut (
    .clk(clk), .rst(rst),
    .f_valid(f_valid), .f_ready(f_ready), .f_pc(f_pc),
    .f_taken_pred(f_taken_pred), .f_addr_pred(f_addr_pred),
    .ex_valid(ex_valid), .ex_is_br(ex_is_br), .ex_pc(ex_pc),
    .ex_taken(ex_taken), .ex_target(ex_target), .flush(flush),
    .w_br_op(w_br_op), .w_pc(w_pc), .w_dest(w_dest), .w_taken(w_taken),
    .redirect(redirect), .redirect_pc(redirect_pc), .count(count),
    .err(err), .stat_br(stat_br), .stat_miss(stat_miss)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic        tp;
    logic [31:0] ap;
  } ent_t;

  typedef struct {
    logic        br;
    logic [31:0] pc;
    logic [31:0] dest;
    logic        tk;
    logic        rd;
    logic [31:0] rpc;
  } exp_t;

  ent_t mq[$];
  exp_t sb[$];
  int checks = 0;
  int errors = 0;
  logic exp_err = 1'b0;
  int exp_br = 0;
  int exp_miss = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic idle_inputs();
    f_valid = 0; f_pc = 0; f_taken_pred = 0; f_addr_pred = 0;
    ex_valid = 0; ex_is_br = 0; ex_pc = 0; ex_taken = 0; ex_target = 0; flush = 0;
  endtask

  // One clock cycle: optional push, optional resolve, optional flush, then check everything.
  task automatic step(input logic fv, input logic [31:0] fpc, input logic ftp, input logic [31:0] fap,
                      input logic ev, input logic eb, input logic [31:0] epc, input logic et,
                      input logic [31:0] etg, input logic fl);
    ent_t e;
    exp_t x;
    logic ready, resolved, mis;
    logic [31:0] pc4, pn, an;
    ready = (mq.size() < 8);
    chk("f_ready", 32'(f_ready), 32'(ready));
    chk("count_pre", 32'(count), 32'(mq.size()));
    f_valid = fv; f_pc = fpc; f_taken_pred = ftp; f_addr_pred = fap;
    ex_valid = ev; ex_is_br = eb; ex_pc = epc; ex_taken = et; ex_target = etg; flush = fl;
    resolved = 0;
    mis = 0;
    if (ev && mq.size() > 0) begin
      e = mq.pop_front();
      pc4 = e.pc + 32'd4;
      pn = e.tp ? e.ap : pc4;
      an = (eb && et) ? etg : pc4;
      mis = (pn != an);
      if (epc != e.pc) exp_err = 1'b1;
`ifdef BP_RESOLVE_STATS_EN
      if (eb) exp_br++;
      if (mis) exp_miss++;
`endif
      x.br = eb; x.pc = e.pc; x.dest = etg; x.tk = et; x.rd = mis && !fl; x.rpc = an;
      sb.push_back(x);
      resolved = 1;
    end else if (ev) begin
      exp_err = 1'b1;
    end
    if (mis || fl) mq.delete();
    else if (fv && ready) begin
      e.pc = fpc; e.tp = ftp; e.ap = fap;
      mq.push_back(e);
    end
    @(posedge clk);
    #1;
    idle_inputs();
    if (resolved) begin
      x = sb.pop_front();
      chk("w_br_op", 32'(w_br_op), 32'(x.br));
      if (x.br) begin
        chk("w_pc", w_pc, x.pc);
        chk("w_dest", w_dest, x.dest);
        chk("w_taken", 32'(w_taken), 32'(x.tk));
      end
      chk("redirect", 32'(redirect), 32'(x.rd));
      if (x.rd) chk("redirect_pc", redirect_pc, x.rpc);
    end else begin
      chk("w_br_op_idle", 32'(w_br_op), 32'd0);
      chk("redirect_idle", 32'(redirect), 32'd0);
    end
    chk("err", 32'(err), 32'(exp_err));
    chk("count", 32'(count), 32'(mq.size()));
    $display("step push=%0b pc=%h resolve=%0b br=%0b tk=%0b tgt=%h flush=%0b -> count=%0d w_br_op=%0b redirect=%0b rpc=%h err=%0b",
             fv, fpc, ev, eb, et, etg, fl, count, w_br_op, redirect, redirect_pc, err);
  endtask

  task automatic push(input logic [31:0] pc, input logic tp, input logic [31:0] ap);
    step(1, pc, tp, ap, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic resolve(input logic eb, input logic et, input logic [31:0] tgt);
    step(0, 0, 0, 0, 1, eb, (mq.size() > 0) ? mq[0].pc : 32'h0, et, tgt, 0);
  endtask

  // Resolve the head exactly as it was predicted.
  task automatic resolve_ok();
    resolve(1, mq[0].tp, mq[0].ap);
  endtask

  initial begin
    idle_inputs();
    rst = 1;
    repeat (3) @(posedge clk);
    #1;
    rst = 0;
    chk("rst_f_ready", 32'(f_ready), 32'd1);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_w_br_op", 32'(w_br_op), 32'd0);
    chk("rst_w_pc", w_pc, 32'd0);
    chk("rst_redirect", 32'(redirect), 32'd0);
    chk("rst_redirect_pc", redirect_pc, 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_stat_br", stat_br, 32'd0);

    // Two correctly predicted branches
    push(32'h100, 0, 32'h0);
    push(32'h104, 1, 32'h200);
    resolve(1, 0, 32'h180);
    resolve(1, 1, 32'h200);

    // Mispredict with a concurrent wrong-path push
    push(32'h100, 0, 32'h0);
    step(1, 32'h500, 0, 0, 1, 1, 32'h100, 1, 32'h180, 0);

    // Fill, overflow attempt, pop with blocked push, then wrap
    for (int i = 0; i < 8; i++) push(32'h1000 + 32'(i * 4), i[0], 32'h2000 + 32'(i * 16));
    push(32'h9999, 0, 0);
    step(1, 32'h8888, 0, 0, 1, 1, mq[0].pc, mq[0].tp, mq[0].ap, 0);
    push(32'h1020, 1, 32'h3000);
    for (int i = 0; i < 8; i++) resolve_ok();

    // Non-branch predicted taken
    push(32'h300, 1, 32'h400);
    resolve(0, 0, 32'h0);

    // Flush alongside a mispredicting resolve
    push(32'h600, 0, 0);
    push(32'h604, 0, 0);
    step(0, 0, 0, 0, 1, 1, 32'h600, 1, 32'h700, 1);

    // Resolve while empty, then error must stay set
    resolve(1, 1, 32'h800);
    push(32'h700, 0, 0);
    resolve_ok();

`ifdef BP_RESOLVE_STATS_EN
    chk("stat_br", stat_br, 32'(exp_br));
    chk("stat_miss", stat_miss, 32'(exp_miss));
`else
    chk("stat_br_off", stat_br, 32'd0);
    chk("stat_miss_off", stat_miss, 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
